// File: rtl/fphub_pkg.sv
// Shared types and helpers for the HUB multiplier arbiter: format geometry,
// FPnew-style status flags, the pipeline entry record and the flag generator.
package fphub_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  // Entries are sized for the widest format/requester count so one record type serves every instance.
  localparam int WIDTH_MAX   = 64;
  localparam int OWNER_W_MAX = 8;

  typedef struct packed {
    logic                   valid;
    logic [OWNER_W_MAX-1:0] owner;
    logic [WIDTH_MAX-1:0]   result;
    status_t                status;
  } pipe_entry_t;

  function automatic int exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int man_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 10;
    endcase
  endfunction

  function automatic int fp_width(input fp_format_e fmt);
    return exp_bits(fmt) + man_bits(fmt) + 1;
  endfunction

  // Saturated magnitude flags overflow, flushed magnitude flags underflow.
  function automatic status_t hub_flags(input logic [WIDTH_MAX-1:0] z, input int width);
    status_t s;
    logic    all_ones;
    logic    all_zeros;
    s         = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int b = 0; b < WIDTH_MAX; b++) begin
      if (b < width - 1) begin
        all_ones  = all_ones & z[b];
        all_zeros = all_zeros & ~z[b];
      end
    end
    s.OF = all_ones;
    s.UF = all_zeros;
    return s;
  endfunction

endpackage

// File: rtl/FPHUB_mult.sv
// Combinational HUB floating-point multiplier: significands carry an implicit
// trailing one, so round-to-nearest reduces to truncation after normalisation.
module FPHUB_mult #(
  parameter  int E = 5,
  parameter  int M = 10,
  localparam int W = E + M + 1
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic [W-1:0] Z
);

  localparam int SW = M + 2;
  localparam int PW = 2 * SW;
  localparam logic [E+1:0] BIAS    = (E+2)'(2**(E-1) - 1);
  localparam logic [E+1:0] EXP_SAT = (E+2)'(2**(E-1) - 1 + 2**E - 1);

  logic          w_sign;
  logic          w_zero_in;
  logic          w_norm;
  logic [E-1:0]  w_ex;
  logic [E-1:0]  w_ey;
  logic [SW-1:0] w_mx;
  logic [SW-1:0] w_my;
  logic [PW-1:0] w_prod;
  logic [E+1:0]  w_exp_sum;
  logic [E-1:0]  w_exp_res;
  logic [M-1:0]  w_man;
  logic          w_prod_unused;

  assign w_sign    = X[W-1] ^ Y[W-1];
  assign w_ex      = X[W-2:M];
  assign w_ey      = Y[W-2:M];
  assign w_zero_in = (w_ex == '0) || (w_ey == '0);
  assign w_mx      = {1'b1, X[M-1:0], 1'b1};
  assign w_my      = {1'b1, Y[M-1:0], 1'b1};
  assign w_prod    = {{SW{1'b0}}, w_mx} * {{SW{1'b0}}, w_my};

  // Product lies in [1,4): one normalisation step at most.
  assign w_norm    = w_prod[PW-1];
  assign w_man     = w_norm ? w_prod[PW-2 -: M] : w_prod[PW-3 -: M];
  assign w_exp_sum = {2'b00, w_ex} + {2'b00, w_ey} + {{(E+1){1'b0}}, w_norm};
  assign w_exp_res = E'(w_exp_sum - BIAS);

  assign w_prod_unused = ^w_prod[PW-M-3:0];

  always_comb begin
    Z = {w_sign, w_exp_res, w_man};
    if (w_zero_in || (w_exp_sum <= BIAS)) begin
      Z = {w_sign, {(W-1){1'b0}}};
    end else if (w_exp_sum >= EXP_SAT) begin
      Z = {w_sign, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fphub_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above the pointer wins, else the
// lowest overall; the pointer moves past the winner only when enabled.
module fphub_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               enable_i,
  output logic [IDX_W-1:0]   ptr_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_req_hi;
  logic [NUM_REQ-1:0] w_pick;
  logic [NUM_REQ-1:0] w_onehot;
  logic [IDX_W-1:0]   w_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_mask[gi] = (IDX_W'(gi) >= r_ptr);
    end
  endgenerate

  assign w_req_hi = req_i & w_mask;
  assign w_pick   = (|w_req_hi) ? w_req_hi : req_i;
  assign w_onehot = w_pick & (~w_pick + NUM_REQ'(1));

  always_comb begin
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_idx = IDX_W'(i);
      end
    end
  end

  assign grant_o     = enable_i ? w_onehot : '0;
  assign grant_idx_o = w_idx;
  assign ptr_o       = r_ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (enable_i && (|req_i)) begin
      r_ptr <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fphub_mult_arbiter.sv
// Shares one combinational HUB multiplier among NUM_REQ requesters through a
// round-robin grant and a PIPE_DEPTH-stage result pipeline with a common stall.
module fphub_mult_arbiter
  import fphub_pkg::*;
#(
  parameter fp_format_e FpFormat   = FP16,
  parameter int         WIDTH      = fp_width(FpFormat),
  parameter int         E          = exp_bits(FpFormat),
  parameter int         M          = man_bits(FpFormat),
  parameter int         NUM_REQ    = 4,
  parameter int         PIPE_DEPTH = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NUM_REQ-1:0]                in_valid_i,
  output logic [NUM_REQ-1:0]                in_ready_o,
  input  logic [NUM_REQ-1:0][1:0][WIDTH-1:0] operands_i,
  output logic [WIDTH-1:0]                  result_o,
  output status_t                           status_o,
  output logic [NUM_REQ-1:0]                out_valid_o,
  input  logic [NUM_REQ-1:0]                out_ready_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  pipe_entry_t        r_pipe [PIPE_DEPTH];
  pipe_entry_t        w_last;
  pipe_entry_t        w_stage0;
  logic               w_head_accept;
  logic               w_stall;
  logic               w_enable;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [IDX_W-1:0]   w_arb_ptr_unused;
  logic [WIDTH-1:0]   w_op_x;
  logic [WIDTH-1:0]   w_op_y;
  logic [WIDTH-1:0]   w_z;

  assign w_last = r_pipe[PIPE_DEPTH-1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_out_valid
      assign out_valid_o[gi] = w_last.valid && (w_last.owner == OWNER_W_MAX'(gi));
    end
    if (WIDTH < WIDTH_MAX) begin : g_result_pad
      logic w_result_unused;
      assign w_result_unused = ^w_last.result[WIDTH_MAX-1:WIDTH];
    end
  endgenerate

  // Granting is held off during reset, flush and whenever the head is blocked.
  assign w_head_accept = |(out_valid_o & out_ready_i);
  assign w_stall       = w_last.valid && !w_head_accept;
  assign w_enable      = rst_ni && !flush_i && !w_stall;

  fphub_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (in_valid_i),
    .enable_i    (w_enable),
    .ptr_o       (w_arb_ptr_unused),
    .grant_o     (w_grant),
    .grant_idx_o (w_grant_idx)
  );

  assign in_ready_o = w_grant;
  assign w_op_x     = operands_i[w_grant_idx][0];
  assign w_op_y     = operands_i[w_grant_idx][1];

  FPHUB_mult #(
    .E (E),
    .M (M)
  ) u_mult (
    .X (w_op_x),
    .Y (w_op_y),
    .Z (w_z)
  );

  always_comb begin
    w_stage0 = '0;
    if (|w_grant) begin
      w_stage0.valid  = 1'b1;
      w_stage0.owner  = OWNER_W_MAX'(w_grant_idx);
      w_stage0.result = WIDTH_MAX'(w_z);
      w_stage0.status = hub_flags(WIDTH_MAX'(w_z), WIDTH);
    end
  end

  // Flush wins over stall; bubbles travel with the data rather than collapsing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_pipe[k] <= '0;
      end
    end else if (!w_stall) begin
      r_pipe[0] <= w_stage0;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign result_o = w_last.valid ? w_last.result[WIDTH-1:0] : '0;
  assign status_o = w_last.valid ? w_last.status : '0;

endmodule

// File: tb/tb_fphub_mult_arbiter.sv
// Directed bench for fphub_mult_arbiter (FP16, 4 requesters, 2 stages) with
// hand-computed HUB products.
module tb_fphub_mult_arbiter;
  import fphub_pkg::*;

  logic                      clk_i = 1'b0;
  logic                      rst_ni;
  logic                      flush_i;
  logic [3:0]                in_valid_i;
  logic [3:0]                in_ready_o;
  logic [3:0][1:0][15:0]     operands_i;
  logic [15:0]               result_o;
  status_t                   status_o;
  logic [3:0]                out_valid_o;
  logic [3:0]                out_ready_i;

  int n_checks;
  int n_errors;

  logic [15:0] gold3 [4];
  logic [15:0] gold6 [4];
  logic [15:0] stat6 [4];

  always #5 clk_i = ~clk_i;

  fphub_mult_arbiter #(
    .NUM_REQ    (4),
    .PIPE_DEPTH (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operands_i  (operands_i),
    .result_o    (result_o),
    .status_o    (status_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [15:0] x, input logic [15:0] y);
    operands_i[idx][0] = x;
    operands_i[idx][1] = y;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    in_valid_i  = 4'hF;
    out_ready_i = 4'hF;
    operands_i  = '0;
    gold3 = '{16'h3C01, 16'h4001, 16'h4401, 16'h4201};
    gold6 = '{16'h7FFF, 16'h0000, 16'hFFFF, 16'h0000};
    stat6 = '{16'h0004, 16'h0002, 16'h0004, 16'h0002};
    set_op(0, 16'h3C00, 16'h3C00);
    set_op(1, 16'h3C00, 16'h4000);
    set_op(2, 16'h4000, 16'h4000);
    set_op(3, 16'h4200, 16'h3C00);

    // Reset held with all requesters valid
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_in_ready", 16'(in_ready_o), 16'h0000);
      check_eq("rst_out_valid", 16'(out_valid_o), 16'h0000);
    end
    check_eq("rst_result", result_o, 16'h0000);
    check_eq("rst_status", 16'(status_o), 16'h0000);
    rst_ni = 1'b1;
    #1;
    check_eq("first_grant", 16'(in_ready_o), 16'h0001);
    in_valid_i = 4'h0;
    tick();

    // Requester 1 alone: 1.0 * 2.0
    in_valid_i = 4'b0010;
    #1;
    check_eq("solo_ready", 16'(in_ready_o), 16'h0002);
    tick();
    in_valid_i = 4'h0;
    check_eq("solo_t1_valid", 16'(out_valid_o), 16'h0000);
    tick();
    check_eq("solo_t2_valid", 16'(out_valid_o), 16'h0002);
    check_eq("solo_result", result_o, 16'h4001);
    check_eq("solo_status", 16'(status_o), 16'h0000);
    tick();
    check_eq("solo_t3_valid", 16'(out_valid_o), 16'h0000);

    // Pointer back to zero, then all four requesters saturate the port
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid_i = (c < 8) ? 4'hF : 4'h0;
      #1;
      check_eq($sformatf("rr_ready_c%0d", c), 16'(in_ready_o),
               (c < 8) ? 16'(1 << (c % 4)) : 16'h0000);
      if (c >= 2) begin
        check_eq($sformatf("rr_valid_c%0d", c), 16'(out_valid_o), 16'(1 << ((c - 2) % 4)));
        check_eq($sformatf("rr_result_c%0d", c), result_o, gold3[(c - 2) % 4]);
      end else begin
        check_eq($sformatf("rr_valid_c%0d", c), 16'(out_valid_o), 16'h0000);
      end
      tick();
    end

    // Owner 2 blocked at the head for five cycles with owner 3 queued behind
    out_ready_i = 4'b1011;
    in_valid_i  = 4'b0100;
    #1;
    check_eq("stall_grant2", 16'(in_ready_o), 16'h0004);
    tick();
    in_valid_i = 4'b1000;
    #1;
    check_eq("stall_grant3", 16'(in_ready_o), 16'h0008);
    tick();
    in_valid_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("stall_ready_%0d", i), 16'(in_ready_o), 16'h0000);
      check_eq($sformatf("stall_valid_%0d", i), 16'(out_valid_o), 16'h0004);
      check_eq($sformatf("stall_result_%0d", i), result_o, 16'h4401);
      tick();
    end
    out_ready_i = 4'hF;
    #1;
    check_eq("drain_grant0", 16'(in_ready_o), 16'h0001);
    check_eq("drain_head2", 16'(out_valid_o), 16'h0004);
    tick();
    in_valid_i = 4'h0;
    check_eq("drain_next3", 16'(out_valid_o), 16'h0008);
    check_eq("drain_result3", result_o, 16'h4201);
    tick();
    check_eq("drain_next0", 16'(out_valid_o), 16'h0001);
    check_eq("drain_result0", result_o, 16'h3C01);
    tick();
    check_eq("drain_empty", 16'(out_valid_o), 16'h0000);
    check_eq("drain_empty_result", result_o, 16'h0000);

    // Flush with two operations in flight (pointer is at 1 here)
    in_valid_i = 4'b0010;
    #1;
    check_eq("flush_pre_grant1", 16'(in_ready_o), 16'h0002);
    tick();
    in_valid_i = 4'b0100;
    #1;
    check_eq("flush_pre_grant2", 16'(in_ready_o), 16'h0004);
    tick();
    flush_i    = 1'b1;
    in_valid_i = 4'b1000;
    #1;
    check_eq("flush_ready", 16'(in_ready_o), 16'h0000);
    check_eq("flush_head", 16'(out_valid_o), 16'h0002);
    tick();
    flush_i    = 1'b0;
    in_valid_i = 4'h0;
    check_eq("flush_out_valid", 16'(out_valid_o), 16'h0000);
    check_eq("flush_result", result_o, 16'h0000);
    in_valid_i = 4'b1001;
    #1;
    check_eq("flush_ptr_kept", 16'(in_ready_o), 16'h0008);
    tick();
    in_valid_i = 4'h0;
    tick();
    check_eq("flush_after_valid", 16'(out_valid_o), 16'h0008);
    check_eq("flush_after_result", result_o, 16'h4201);

    // Saturation and flush-to-zero flags
    set_op(0, 16'h7BFF, 16'h7BFF);
    set_op(1, 16'h0400, 16'h0400);
    set_op(2, 16'h7BFF, 16'hFBFF);
    set_op(3, 16'h0000, 16'h3C00);
    for (int c = 0; c < 6; c++) begin
      in_valid_i = (c < 4) ? 4'(1 << c) : 4'h0;
      #1;
      if (c < 4) begin
        check_eq($sformatf("sat_ready_c%0d", c), 16'(in_ready_o), 16'(1 << c));
      end
      if (c >= 2) begin
        check_eq($sformatf("sat_valid_c%0d", c), 16'(out_valid_o), 16'(1 << (c - 2)));
        check_eq($sformatf("sat_result_c%0d", c), result_o, gold6[c - 2]);
        check_eq($sformatf("sat_status_c%0d", c), 16'(status_o), stat6[c - 2]);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
